// File: rtl/hd44780_nybble_writer.sv
// rtl/hd44780_nybble_writer.sv - HD44780 4-bit bus write engine with setup/pulse/hold and execution delay timing
module hd44780_nybble_writer #(
    parameter int T_SETUP     = 2,
    parameter int T_EPW       = 12,
    parameter int T_HOLD      = 2,
    parameter int T_ELOW      = 14,
    parameter int DELAY_SHORT = 1776,
    parameter int DELAY_LONG  = 73000
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    input  logic       RS_I,
    input  logic       NYB_I,
    input  logic       LONG_I,
    output logic       BUSY_O,
    output logic       ACK_O,
    output logic [3:0] LCD_D,
    output logic       LCD_RS,
    output logic       LCD_E
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_ELOW,
        S_DELAY
    } state_t;

    // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [16:0] L_SETUP = 17'(T_SETUP - 1);
    localparam logic [16:0] L_EPW   = 17'(T_EPW - 1);
    localparam logic [16:0] L_HOLD  = 17'(T_HOLD - 1);
    localparam logic [16:0] L_ELOW  = 17'(T_ELOW - 1);
    localparam logic [16:0] L_SHORT = 17'(DELAY_SHORT - 1);
    localparam logic [16:0] L_LONG  = 17'(DELAY_LONG - 1);

    state_t      state, state_n;
    logic [16:0] cnt, cnt_n;
    logic [3:0]  lo_q, lo_n;
    logic        nyb_q, nyb_n;
    logic        long_q, long_n;
    logic        second_q, second_n;
    logic [3:0]  lcd_d_n;
    logic        lcd_rs_n, lcd_e_n, busy_n, ack_n;
    logic        done, accept;

    // State, counter, latched request and all outputs are registered together.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lo_q     <= '0;
            nyb_q    <= 1'b0;
            long_q   <= 1'b0;
            second_q <= 1'b0;
            LCD_D    <= '0;
            LCD_RS   <= 1'b0;
            LCD_E    <= 1'b0;
            BUSY_O   <= 1'b0;
            ACK_O    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lo_q     <= lo_n;
            nyb_q    <= nyb_n;
            long_q   <= long_n;
            second_q <= second_n;
            LCD_D    <= lcd_d_n;
            LCD_RS   <= lcd_rs_n;
            LCD_E    <= lcd_e_n;
            BUSY_O   <= busy_n;
            ACK_O    <= ack_n;
        end
    end

    // Next-state and next-output decode; a new request may be taken in IDLE or on the ACK edge.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lo_n     = lo_q;
        nyb_n    = nyb_q;
        long_n   = long_q;
        second_n = second_q;
        lcd_d_n  = LCD_D;
        lcd_rs_n = LCD_RS;
        lcd_e_n  = LCD_E;
        busy_n   = BUSY_O;
        ack_n    = 1'b0;
        accept   = 1'b0;
        done     = (cnt == '0);
        if (!done) begin
            cnt_n = cnt - 17'd1;
        end

        case (state)
            S_IDLE: begin
                accept = STB_I;
            end
            S_SETUP: begin
                if (done) begin
                    lcd_e_n = 1'b1;
                    cnt_n   = L_EPW;
                    state_n = S_EHIGH;
                end
            end
            S_EHIGH: begin
                if (done) begin
                    lcd_e_n = 1'b0;
                    cnt_n   = L_HOLD;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (done) begin
                    if (!second_q && !nyb_q) begin
                        lcd_d_n  = lo_q;
                        second_n = 1'b1;
                        cnt_n    = L_ELOW;
                        state_n  = S_ELOW;
                    end else begin
                        cnt_n   = long_q ? L_LONG : L_SHORT;
                        state_n = S_DELAY;
                    end
                end
            end
            S_ELOW: begin
                if (done) begin
                    lcd_e_n = 1'b1;
                    cnt_n   = L_EPW;
                    state_n = S_EHIGH;
                end
            end
            S_DELAY: begin
                if (done) begin
                    ack_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                    accept  = STB_I;
                end
            end
            default: begin
                state_n = S_IDLE;
                lcd_e_n = 1'b0;
                busy_n  = 1'b0;
                cnt_n   = '0;
            end
        endcase

        // Latch the request and present the high nybble; E stays low through SETUP.
        if (accept) begin
            lo_n     = DAT_I[3:0];
            nyb_n    = NYB_I;
            long_n   = LONG_I;
            second_n = 1'b0;
            lcd_d_n  = DAT_I[7:4];
            lcd_rs_n = RS_I;
            lcd_e_n  = 1'b0;
            busy_n   = 1'b1;
            cnt_n    = L_SETUP;
            state_n  = S_SETUP;
        end
    end

endmodule
